// File: rtl/raster_ram_writer_pkg.sv
// Shared types for the raster RAM writer: FSM state encoding and the
// word-index to byte-address shift.
package raster_ram_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // 4-byte bus words: byte address = base + (index << BYTE_SHIFT)
    localparam int unsigned BYTE_SHIFT = 2;

endpackage

// File: rtl/raster_ram_writer_ring_index.sv
// Ring bookkeeping for the RAM writer: write index, latched kernel read index,
// and the derived fill count / full flag (one slot is always kept empty).
module ring_index #(
    parameter int PTR_WID = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    input  logic [PTR_WID-1:0] cfg_len,
    input  logic [PTR_WID-1:0] kernel_rd_ptr,
    output logic [PTR_WID-1:0] wr_ptr,
    output logic [PTR_WID-1:0] count,
    output logic               full
);

    logic [PTR_WID-1:0] wr_q, wr_d, wr_inc;
    logic [PTR_WID-1:0] rd_q;

    always_comb begin
        wr_inc = wr_q + PTR_WID'(1);
        wr_d   = (wr_inc == cfg_len) ? '0 : wr_inc;
        // modular distance without needing a wider intermediate
        count  = (wr_q >= rd_q) ? (wr_q - rd_q) : (wr_q + (cfg_len - rd_q));
        full   = (count == (cfg_len - PTR_WID'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (inc) begin
                wr_q <= wr_d;
            end
            if (kernel_rd_ptr < cfg_len) begin
                rd_q <= kernel_rd_ptr;
            end
        end
    end

    assign wr_ptr = wr_q;

endmodule

// File: rtl/raster_ram_writer.sv
// Scanner-to-RAM bridge: one Wishbone write per committed ADC word into a ring.
// Optional RAM_WRITER_DROP_ON_FULL_EN: drop words while full instead of stalling.
module raster_ram_writer
    import raster_ram_writer_pkg::*;
#(
    parameter int MAX_ADC_DATA_WID = 24,
    parameter int BUS_DATA_WID     = 32,
    parameter int BUS_ADR_WID      = 32,
    parameter int PTR_WID          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_ADC_DATA_WID-1:0] data,
    input  logic                        mem_commit,
    output logic                        mem_finished,
    input  logic [BUS_ADR_WID-1:0]      cfg_base,
    input  logic [PTR_WID-1:0]          cfg_len,
    input  logic                        clear,
    input  logic [PTR_WID-1:0]          kernel_rd_ptr,
    output logic [PTR_WID-1:0]          wr_ptr,
    output logic [PTR_WID-1:0]          count,
    output logic                        overflow,
`ifdef RAM_WRITER_DROP_ON_FULL_EN
    output logic [PTR_WID-1:0]          drop_count,
`endif
    output logic                        wb_cyc,
    output logic                        wb_stb,
    output logic                        wb_we,
    output logic [BUS_ADR_WID-1:0]      wb_adr,
    output logic [BUS_DATA_WID-1:0]     wb_dat_w,
    output logic [BUS_DATA_WID/8-1:0]   wb_sel,
    input  logic                        wb_ack
);

    // state    | meaning
    // ST_IDLE  | waiting for a commit; clear acts immediately
    // ST_WRITE | bus cycle open, holding adr/dat until ack
    // ST_DONE  | mem_finished high until the scanner drops mem_commit

    state_e                     state_q;
    logic                       cyc_q, stb_q, we_q, fin_q, ovf_q, clr_pend_q;
    logic [BUS_ADR_WID-1:0]     adr_q, adr_d;
    logic [BUS_DATA_WID-1:0]    dat_q, dat_d;
    logic signed [MAX_ADC_DATA_WID-1:0] data_s;
    logic                       full, ring_inc, ring_clear, done_exit;
`ifdef RAM_WRITER_DROP_ON_FULL_EN
    logic [PTR_WID-1:0]         drop_q;
`endif

    assign data_s     = data;
    assign dat_d      = BUS_DATA_WID'(data_s);
    assign adr_d      = cfg_base + (BUS_ADR_WID'(wr_ptr) << BYTE_SHIFT);
    assign done_exit  = (state_q == ST_DONE) && !mem_commit;
    assign ring_inc   = (state_q == ST_WRITE) && wb_ack;
    // a clear seen mid-transfer is parked and applied on the way back to IDLE
    assign ring_clear = ((state_q == ST_IDLE) && clear) ||
                        (done_exit && (clear || clr_pend_q));

    ring_index #(.PTR_WID(PTR_WID)) u_ring (
        .clk           (clk),
        .rst           (rst),
        .clear         (ring_clear),
        .inc           (ring_inc),
        .cfg_len       (cfg_len),
        .kernel_rd_ptr (kernel_rd_ptr),
        .wr_ptr        (wr_ptr),
        .count         (count),
        .full          (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            fin_q      <= 1'b0;
            ovf_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
`ifdef RAM_WRITER_DROP_ON_FULL_EN
            drop_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        ovf_q  <= 1'b0;
`ifdef RAM_WRITER_DROP_ON_FULL_EN
                        drop_q <= '0;
`endif
                    end else if (mem_commit) begin
                        if (!full) begin
                            state_q <= ST_WRITE;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b1;
                            adr_q   <= adr_d;
                            dat_q   <= dat_d;
                        end else begin
                            ovf_q <= 1'b1;
`ifdef RAM_WRITER_DROP_ON_FULL_EN
                            state_q <= ST_DONE;
                            fin_q   <= 1'b1;
                            if (drop_q != '1) begin
                                drop_q <= drop_q + PTR_WID'(1);
                            end
`endif
                        end
                    end
                end
                ST_WRITE: begin
                    if (clear) begin
                        clr_pend_q <= 1'b1;
                    end
                    if (wb_ack) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        fin_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!mem_commit) begin
                        fin_q      <= 1'b0;
                        clr_pend_q <= 1'b0;
                        state_q    <= ST_IDLE;
                        if (clear || clr_pend_q) begin
                            ovf_q  <= 1'b0;
`ifdef RAM_WRITER_DROP_ON_FULL_EN
                            drop_q <= '0;
`endif
                        end
                    end else if (clear) begin
                        clr_pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_finished = fin_q;
    assign overflow     = ovf_q;
    assign wb_cyc       = cyc_q;
    assign wb_stb       = stb_q;
    assign wb_we        = we_q;
    assign wb_adr       = adr_q;
    assign wb_dat_w     = dat_q;
    assign wb_sel       = '1;
`ifdef RAM_WRITER_DROP_ON_FULL_EN
    assign drop_count   = drop_q;
`endif

endmodule
